alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (req0: execute stage, req1: address/CSR helper).

---
 rtl/alu_share_if.sv | 36 +++
 rtl/alu_share_arbiter.sv | 94 +++++++++
 tb/tb_alu_share_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Bundle of requester, response and ALU-side signals around the shared ALU arbiter.
interface alu_share_if #(
  parameter int DW  = 32,
  parameter int OPW = 4
);
  logic           req0_valid_i, req1_valid_i;
  logic           req0_ready_o, req1_ready_o;
  logic [DW-1:0]  req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
  logic [OPW-1:0] req0_op_i, req1_op_i;
  logic           req0_lock_i, req1_lock_i;
  logic           rsp0_valid_o, rsp1_valid_o;
  logic           rsp0_ready_i, rsp1_ready_i;
  logic [DW-1:0]  rsp0_res_o, rsp1_res_o;
  logic [2:0]     rsp0_flags_o, rsp1_flags_o;
  logic [DW-1:0]  alu_data1_o, alu_data2_o;
  logic [OPW-1:0] alu_op_code_o;
  logic [DW-1:0]  alu_res_i;
  logic           alu_zero_flag_i, alu_sign_flag_i, alu_overflow_flag_i;
  logic [15:0]    conflict_cnt_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i,
           req0_op_i, req1_op_i, req0_lock_i, req1_lock_i, rsp0_ready_i, rsp1_ready_i,
           alu_res_i, alu_zero_flag_i, alu_sign_flag_i, alu_overflow_flag_i,
    output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_res_o, rsp1_res_o,
           rsp0_flags_o, rsp1_flags_o, alu_data1_o, alu_data2_o, alu_op_code_o, conflict_cnt_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i,
           req0_op_i, req1_op_i, req0_lock_i, req1_lock_i, rsp0_ready_i, rsp1_ready_i,
           alu_res_i, alu_zero_flag_i, alu_sign_flag_i, alu_overflow_flag_i,
    input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_res_o, rsp1_res_o,
           rsp0_flags_o, rsp1_flags_o, alu_data1_o, alu_data2_o, alu_op_code_o, conflict_cnt_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin/lock arbiter for one shared combinational ALU,
// with a registered one-deep response slot per requester.
module alu_share_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_share_if.slave  bus
);
  typedef enum logic [1:0] {ST_RR, ST_LOCK0, ST_LOCK1} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rr_ptr;
  logic [1:0]           r_rsp_vld;
  logic [1:0][DW-1:0]   r_rsp_res;
  logic [1:0][2:0]      r_rsp_flags;
  logic [15:0]          r_conflict_cnt;

  logic [1:0]           w_req_vld, w_rsp_rdy, w_lock, w_elig, w_grant;
  logic [2:0]           w_alu_flags;

  assign w_req_vld   = {bus.req1_valid_i, bus.req0_valid_i};
  assign w_rsp_rdy   = {bus.rsp1_ready_i, bus.rsp0_ready_i};
  assign w_lock      = {bus.req1_lock_i, bus.req0_lock_i};
  assign w_alu_flags = {bus.alu_overflow_flag_i, bus.alu_sign_flag_i, bus.alu_zero_flag_i};
  // A requester may go only if its slot is empty or emptying this cycle.
  assign w_elig      = w_req_vld & (~r_rsp_vld | w_rsp_rdy);

  always_comb begin
    w_grant     = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCK0: w_grant[0] = w_elig[0];
      ST_LOCK1: w_grant[1] = w_elig[1];
      default: begin
        if (&w_elig) w_grant[r_rr_ptr] = 1'b1;
        else         w_grant = w_elig;
      end
    endcase
    if (w_grant[0])      w_state_nxt = w_lock[0] ? ST_LOCK0 : ST_RR;
    else if (w_grant[1]) w_state_nxt = w_lock[1] ? ST_LOCK1 : ST_RR;
  end

  always_comb begin
    bus.alu_data1_o   = '0;
    bus.alu_data2_o   = '0;
    bus.alu_op_code_o = '0;
    if (w_grant[0]) begin
      bus.alu_data1_o   = bus.req0_data1_i;
      bus.alu_data2_o   = bus.req0_data2_i;
      bus.alu_op_code_o = bus.req0_op_i;
    end else if (w_grant[1]) begin
      bus.alu_data1_o   = bus.req1_data1_i;
      bus.alu_data2_o   = bus.req1_data2_i;
      bus.alu_op_code_o = bus.req1_op_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_RR;
      r_rr_ptr       <= 1'b0;
      r_rsp_vld      <= '0;
      r_rsp_res      <= '0;
      r_rsp_flags    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Winner of an RR accept yields priority to the other side.
      if (r_state == ST_RR && |w_grant) r_rr_ptr <= w_grant[0];
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_rsp_vld[i]   <= 1'b1;
          r_rsp_res[i]   <= bus.alu_res_i;
          r_rsp_flags[i] <= w_alu_flags;
        end else if (r_rsp_vld[i] && w_rsp_rdy[i]) begin
          r_rsp_vld[i]   <= 1'b0;
        end
      end
      if (&w_elig && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign bus.req0_ready_o   = w_grant[0];
  assign bus.req1_ready_o   = w_grant[1];
  assign bus.rsp0_valid_o   = r_rsp_vld[0];
  assign bus.rsp1_valid_o   = r_rsp_vld[1];
  assign bus.rsp0_res_o     = r_rsp_res[0];
  assign bus.rsp1_res_o     = r_rsp_res[1];
  assign bus.rsp0_flags_o   = r_rsp_flags[0];
  assign bus.rsp1_flags_o   = r_rsp_flags[1];
  assign bus.conflict_cnt_o = r_conflict_cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU (0=ADD, 1=SUB).
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_share_if #(.DW(DW), .OPW(4)) bus ();

  alu_share_arbiter #(.DW(DW), .OPW(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] a, b, r;
  always_comb begin
    a = bus.alu_data1_o;
    b = bus.alu_data2_o;
    r = (bus.alu_op_code_o == OP_SUB) ? a - b : a + b;
    bus.alu_res_i           = r;
    bus.alu_zero_flag_i     = (r == '0);
    bus.alu_sign_flag_i     = r[DW-1];
    bus.alu_overflow_flag_i = (bus.alu_op_code_o == OP_SUB) ? ((a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]))
                                                            : ((a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2, input logic lk);
    bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_data1_i = d1; bus.req0_data2_i = d2; bus.req0_lock_i = lk;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2, input logic lk);
    bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_data1_i = d1; bus.req1_data2_i = d2; bus.req1_lock_i = lk;
  endtask

  initial begin
    set0(1'b0, OP_ADD, 0, 0, 1'b0);
    set1(1'b0, OP_ADD, 0, 0, 1'b0);
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset rsp0_valid", 32'(bus.rsp0_valid_o), 0);
    chk("reset rsp1_valid", 32'(bus.rsp1_valid_o), 0);
    chk("reset rsp0_res", bus.rsp0_res_o, 0);
    chk("reset rsp1_flags", 32'(bus.rsp1_flags_o), 0);
    chk("reset conflict_cnt", 32'(bus.conflict_cnt_o), 0);

    // single ADD 5+7 on req0
    set0(1'b1, OP_ADD, 5, 7, 1'b0);
    #1;
    chk("add req0_ready", 32'(bus.req0_ready_o), 1);
    chk("add req1_ready", 32'(bus.req1_ready_o), 0);
    chk("add alu_data1", bus.alu_data1_o, 5);
    step();
    set0(1'b0, OP_ADD, 0, 0, 1'b0);
    chk("add rsp0_valid", 32'(bus.rsp0_valid_o), 1);
    chk("add rsp0_res", bus.rsp0_res_o, 12);
    chk("add rsp0_flags", 32'(bus.rsp0_flags_o), 0);

    // tie every cycle; pointer now favours req1
    set0(1'b1, OP_ADD, 10, 1, 1'b0);
    set1(1'b1, OP_ADD, 20, 2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr req0_ready", 32'(bus.req0_ready_o), 32'(c % 2));
      chk("rr req1_ready", 32'(bus.req1_ready_o), 32'(1 - c % 2));
      step();
      if (c == 0) chk("rr rsp1_res", bus.rsp1_res_o, 22);
    end
    set0(1'b0, OP_ADD, 0, 0, 1'b0);
    set1(1'b0, OP_ADD, 0, 0, 1'b0);
    chk("rr conflict_cnt", 32'(bus.conflict_cnt_o), 4);
    chk("rr rsp0_res", bus.rsp0_res_o, 11);

    // flag cases
    set0(1'b1, OP_SUB, 32'h8000_0000, 1, 1'b0);
    step();
    chk("sub res", bus.rsp0_res_o, 32'h7FFF_FFFF);
    chk("sub flags", 32'(bus.rsp0_flags_o), 32'b100);
    set0(1'b1, OP_ADD, 3, 32'hFFFF_FFFD, 1'b0);
    step();
    chk("zero res", bus.rsp0_res_o, 0);
    chk("zero flags", 32'(bus.rsp0_flags_o), 32'b001);
    set0(1'b1, OP_SUB, 2, 5, 1'b0);
    step();
    chk("neg flags", 32'(bus.rsp0_flags_o), 32'b010);

    // req1 locks for three ops, fourth op releases; req0 waits throughout
    set0(1'b1, OP_ADD, 9, 9, 1'b0);
    for (int c = 0; c < 4; c++) begin
      set1(1'b1, OP_ADD, 1, 32'(c), (c < 3) ? 1'b1 : 1'b0);
      #1;
      chk("lock req0_ready", 32'(bus.req0_ready_o), 0);
      chk("lock req1_ready", 32'(bus.req1_ready_o), 1);
      step();
    end
    chk("lock rsp1_res", bus.rsp1_res_o, 4);
    set1(1'b0, OP_ADD, 0, 0, 1'b0);
    #1;
    chk("unlock req0_ready", 32'(bus.req0_ready_o), 1);
    step();
    chk("lock conflict_cnt", 32'(bus.conflict_cnt_o), 8);
    chk("unlock rsp0_res", bus.rsp0_res_o, 18);

    // req0 slot full and stalled; req1 still served
    bus.rsp0_ready_i = 1'b0;
    set0(1'b1, OP_ADD, 100, 1, 1'b0);
    set1(1'b1, OP_ADD, 40, 2, 1'b0);
    #1;
    chk("stall req0_ready", 32'(bus.req0_ready_o), 0);
    chk("stall req1_ready", 32'(bus.req1_ready_o), 1);
    step();
    chk("stall rsp0_res held", bus.rsp0_res_o, 18);
    chk("stall rsp0_valid", 32'(bus.rsp0_valid_o), 1);
    chk("stall rsp1_res", bus.rsp1_res_o, 42);
    chk("stall conflict_cnt", 32'(bus.conflict_cnt_o), 8);
    set1(1'b0, OP_ADD, 0, 0, 1'b0);
    bus.rsp0_ready_i = 1'b1;
    #1;
    chk("drain req0_ready", 32'(bus.req0_ready_o), 1);
    step();
    chk("drain rsp0_valid", 32'(bus.rsp0_valid_o), 1);
    chk("drain rsp0_res", bus.rsp0_res_o, 101);
    chk("drain rsp1_valid", 32'(bus.rsp1_valid_o), 0);

    // build LOCK0 with rsp1 held full, then reset
    set0(1'b0, OP_ADD, 0, 0, 1'b0);
    set1(1'b1, OP_ADD, 2, 3, 1'b0);
    bus.rsp1_ready_i = 1'b0;
    step();
    set1(1'b0, OP_ADD, 0, 0, 1'b0);
    set0(1'b1, OP_ADD, 6, 6, 1'b1);
    #1;
    chk("lock0 req0_ready", 32'(bus.req0_ready_o), 1);
    step();
    chk("lock0 rsp1_valid", 32'(bus.rsp1_valid_o), 1);
    chk("lock0 rsp1_res", bus.rsp1_res_o, 5);
    set0(1'b1, OP_ADD, 1, 1, 1'b0);
    set1(1'b1, OP_ADD, 1, 1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post-rst rsp0_valid", 32'(bus.rsp0_valid_o), 0);
    chk("post-rst rsp1_valid", 32'(bus.rsp1_valid_o), 0);
    chk("post-rst conflict_cnt", 32'(bus.conflict_cnt_o), 0);
    chk("post-rst tie req0_ready", 32'(bus.req0_ready_o), 1);
    chk("post-rst tie req1_ready", 32'(bus.req1_ready_o), 0);
    set0(1'b0, OP_ADD, 0, 0, 1'b0);
    #1;
    chk("post-rst rr req1_ready", 32'(bus.req1_ready_o), 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
